mii_rx_framer: RTL
==================

MII_RX_FRAMER -- requirements
Module: mii_rx_framer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1522, which is the maximum number of bytes written per frame, counted after the SFD.
REQ-002 SHALL have port clk, input, 1 bit: the MII receive clock; all logic is on this clock.
REQ-003 SHALL have port arst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 SHALL have port mii_rxd, input, 4 bits: the receive nibble.
REQ-005 SHALL have port mii_rx_dv, input, 1 bit: receive data valid.
REQ-006 SHALL have port mii_rx_er, input, 1 bit: receive error.
REQ-007 SHALL have port fifo_din, output, 8 bits: the byte written to the PHY FIFO.
REQ-008 SHALL have port fifo_del, output, 1 bit: the delimiter flag; high only on the last byte of a frame.
REQ-009 SHALL have port fifo_wren, output, 1 bit: the PHY FIFO write enable.
REQ-010 SHALL have port fifo_afull, input, 1 bit: PHY FIFO almost full; at least 2 free entries remain while it is asserted.
REQ-011 SHALL have port frame_done, output, 1 bit: a one-cycle pulse coincident with every write where fifo_del is high.

Function
REQ-012 SHALL use the states S_WAIT, S_IDLE, S_PREAMBLE, S_DATA, S_FLUSH and S_DISCARD.
REQ-013 S_WAIT SHALL hold until mii_rx_dv is low for one cycle, then go to S_IDLE.
REQ-014 S_IDLE SHALL go to S_PREAMBLE when mii_rx_dv is high and mii_rxd equals 4'h5.
REQ-015 S_PREAMBLE SHALL go to S_DATA on nibble 4'hD (SFD), provided fifo_afull is low; it stays on 4'h5.
REQ-016 S_PREAMBLE SHALL go to S_DISCARD on any other nibble, or on the SFD while fifo_afull is high; a frame dropped this way writes nothing.
REQ-017 S_PREAMBLE SHALL return to S_IDLE if mii_rx_dv goes low.
REQ-018 In S_DATA the first nibble of each pair SHALL be the low nibble and the second the high nibble; completing the pair assembles one byte.
REQ-019 Each assembled byte SHALL be held in a one-byte staging register; the previously staged byte is written (fifo_wren=1, fifo_del=0) in the cycle after the new byte completes.
REQ-020 When mii_rx_dv falls in S_DATA, the state SHALL go to S_FLUSH, which writes the staged byte with fifo_del=1 on the next cycle and then goes to S_IDLE.
REQ-021 An odd trailing nibble (dribble) SHALL be discarded.
REQ-022 If zero bytes were staged when mii_rx_dv falls, nothing SHALL be written.
REQ-023 mii_rx_er high in S_DATA, fifo_afull high when a byte completes, or the byte count reaching MAX_LEN SHALL each terminate the frame: the staged byte (or the current byte if none is staged) is written with fifo_del=1, and the state goes to S_DISCARD.
REQ-024 S_DISCARD SHALL ignore all input and go to S_IDLE when mii_rx_dv is low.
REQ-025 There SHALL be at most one write per 2 cycles, and at most one write with fifo_del=1 per frame.
REQ-026 The byte counter SHALL be 11 bits, cleared on the SFD, and SHALL saturate at MAX_LEN.
REQ-027 mii_rx_er while in S_IDLE or S_PREAMBLE SHALL force S_DISCARD.
REQ-028 fifo_din, fifo_del, fifo_wren and frame_done SHALL be registered.

Reset
REQ-029 While arst is high: fifo_din=8'h00, fifo_del=0, fifo_wren=0, frame_done=0, all counters are 0, the staging register is empty, and the state is S_WAIT.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no delimiter written; no partial resync is attempted.

Configuration
REQ-031 With MII_RX_STATS_EN defined, the block SHALL add 16-bit saturating outputs stat_ok, stat_err and stat_drop, reset to 0.
- stat_ok increments on each normal S_FLUSH delimiter.
- stat_err increments on each rx_er, MAX_LEN, or preamble-violation termination.
- stat_drop increments on each fifo_afull drop or truncation.
REQ-032 Without MII_RX_STATS_EN, these ports and their counters SHALL be absent, and all other behaviour is identical.

Structure
REQ-033 The shared package mii_rx_pkg SHALL hold:
- the state enumeration;
- MII_PREAMBLE_NIB=4'h5 and MII_SFD_NIB=4'hD;
- the default MAX_LEN and the statistics counter width.
REQ-034 Sub-module mii_nibble_pack SHALL perform nibble-pair assembly and produce a byte-valid strobe; all other logic is flat.

Verification
REQ-035 Stimulus: 7x 4'h5, then 4'hD, then 64 bytes 00..3F, with no error. Required response: 64 writes in order, only byte 3F has fifo_del=1, exactly one frame_done, stat_ok=1.
REQ-036 Stimulus: mii_rx_er pulsed at byte 10 of a 100-byte frame. Required response: exactly 10 or 11 writes, the last has fifo_del=1, no further writes until the next preamble, stat_err=1.
REQ-037 Stimulus: fifo_afull held high through the SFD. Required response: zero writes, stat_drop=1. Stimulus: fifo_afull rising at byte 20. Required response: a delimiter-terminated write with at most 22 writes total.
REQ-038 Stimulus: a 1600-byte frame. Required response: exactly 1522 writes, the last with fifo_del=1, then discard until mii_rx_dv falls, stat_err=1.
REQ-039 Stimulus: arst released while mii_rx_dv is high mid-frame, followed by a valid 64-byte frame. Required response: no writes from the first frame, the second frame intact.
REQ-040 Stimulus: a frame with an odd trailing nibble, and separately an SFD followed immediately by mii_rx_dv low. Required response: the dribble nibble is dropped; the SFD-only frame produces zero writes.

Source files
------------

// File: rtl/mii_rx_pkg.sv
// Shared definitions for the MII receive framer: FSM states, MII nibble
// codes, default frame length limit and statistics counter width.
package mii_rx_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_FLUSH,
    S_DISCARD
  } mii_state_e;

  localparam logic [3:0] MII_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] MII_SFD_NIB      = 4'hD;

  localparam int MII_DEF_MAX_LEN = 1522;
  localparam int MII_CNT_W       = 11;
  localparam int MII_STAT_W      = 16;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [MII_STAT_W-1:0] stat_inc(input logic [MII_STAT_W-1:0] v,
                                                     input logic                  en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/mii_nibble_pack.sv
// Nibble-pair assembler: the first nibble of a pair is the low nibble, the
// second the high nibble. o_byte_vld is a combinational strobe in the cycle
// the high nibble is presented; o_byte is valid only with that strobe.
module mii_nibble_pack
  import mii_rx_pkg::*;
(
  input  logic       clk,
  input  logic       arst,
  input  logic       i_clr,
  input  logic       i_vld,
  input  logic [3:0] i_nib,
  output logic [7:0] o_byte,
  output logic       o_byte_vld
);

  logic       r_phase;
  logic [3:0] r_low;

  // Track pair phase and hold the low nibble until the high one arrives.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_phase <= 1'b0;
      r_low   <= 4'h0;
    end else if (i_clr) begin
      r_phase <= 1'b0;
    end else if (i_vld) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values present before the clock edge.
      r_phase <= ~r_phase;
      if (!r_phase) begin
        r_low <= i_nib;
      end
    end
  end

  assign o_byte     = {i_nib, r_low};
  assign o_byte_vld = i_vld & r_phase & ~i_clr;

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs nibbles into bytes and
// writes them to the PHY FIFO through a one-byte staging register so the
// final byte of a frame can carry the delimiter flag.
// Optional feature: define MII_RX_STATS_EN to add saturating frame
// statistics outputs stat_ok, stat_err and stat_drop.
module mii_rx_framer
  import mii_rx_pkg::*;
#(
  parameter int MAX_LEN = MII_DEF_MAX_LEN
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [3:0]            mii_rxd,
  input  logic                  mii_rx_dv,
  input  logic                  mii_rx_er,
  output logic [7:0]            fifo_din,
  output logic                  fifo_del,
  output logic                  fifo_wren,
  input  logic                  fifo_afull,
  output logic                  frame_done
`ifdef MII_RX_STATS_EN
  ,
  output logic [MII_STAT_W-1:0] stat_ok,
  output logic [MII_STAT_W-1:0] stat_err,
  output logic [MII_STAT_W-1:0] stat_drop
`endif
);

  localparam logic [MII_CNT_W-1:0] LP_MAX = MII_CNT_W'(MAX_LEN);

  mii_state_e           r_state;
  mii_state_e           w_state_nxt;

  logic [7:0]           r_stage;
  logic                 r_stage_vld;
  logic [MII_CNT_W-1:0] r_cnt;
  logic                 r_abort;

  logic [7:0]           r_fifo_din;
  logic                 r_fifo_del;
  logic                 r_fifo_wren;
  logic                 r_frame_done;

  logic [7:0]           w_stage_nxt;
  logic                 w_stage_vld_nxt;
  logic [MII_CNT_W-1:0] w_cnt_nxt;
  logic                 w_abort_nxt;
  logic                 w_wr;
  logic [7:0]           w_wr_din;
  logic                 w_wr_del;
  logic                 w_sfd;

  logic                 w_pack_vld;
  logic [7:0]           w_byte;
  logic                 w_byte_vld;

  logic                 w_term_err;
  logic                 w_term_drop;

  // Nibble data is only meaningful while a frame body is being received.
  assign w_pack_vld = (r_state == S_DATA) && mii_rx_dv;

  mii_nibble_pack u_pack (
    .clk        (clk),
    .arst       (arst),
    .i_clr      (w_sfd),
    .i_vld      (w_pack_vld),
    .i_nib      (mii_rxd),
    .o_byte     (w_byte),
    .o_byte_vld (w_byte_vld)
  );

  // Classify frame-ending conditions: errors (rx_er, bad preamble, over-length)
  // versus drops caused by FIFO back-pressure.
  always_comb begin
    w_term_err  = 1'b0;
    w_term_drop = 1'b0;
    if (mii_rx_dv) begin
      if (r_state == S_PREAMBLE) begin
        w_term_err  = mii_rx_er ||
                      ((mii_rxd != MII_PREAMBLE_NIB) && (mii_rxd != MII_SFD_NIB));
        w_term_drop = !mii_rx_er && (mii_rxd == MII_SFD_NIB) && fifo_afull;
      end else if (r_state == S_DATA) begin
        w_term_err  = mii_rx_er || (w_byte_vld && (r_cnt == LP_MAX));
        w_term_drop = !w_term_err && w_byte_vld && fifo_afull;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, staging and FIFO write decisions.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_wr            = 1'b0;
    w_wr_din        = r_stage;
    w_wr_del        = 1'b0;
    w_stage_nxt     = r_stage;
    w_stage_vld_nxt = r_stage_vld;
    w_cnt_nxt       = r_cnt;
    w_abort_nxt     = r_abort;
    w_sfd           = 1'b0;

    unique case (r_state)
      S_WAIT: begin
        // Never join a frame already in progress.
        if (!mii_rx_dv) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_IDLE: begin
        if (mii_rx_er) begin
          w_state_nxt = S_DISCARD;
        end else if (mii_rx_dv && (mii_rxd == MII_PREAMBLE_NIB)) begin
          w_state_nxt = S_PREAMBLE;
        end
      end

      S_PREAMBLE: begin
        if (!mii_rx_dv) begin
          w_state_nxt = S_IDLE;
        end else if (w_term_err || w_term_drop) begin
          w_state_nxt = S_DISCARD;
        end else if (mii_rxd == MII_SFD_NIB) begin
          w_state_nxt     = S_DATA;
          w_sfd           = 1'b1;
          w_cnt_nxt       = '0;
          w_stage_vld_nxt = 1'b0;
          w_abort_nxt     = 1'b0;
        end
      end

      S_DATA: begin
        if (!mii_rx_dv) begin
          // A pending low nibble (dribble) is simply abandoned.
          w_state_nxt = r_stage_vld ? S_FLUSH : S_IDLE;
        end else if (w_term_err || w_term_drop) begin
          // The delimiter goes out through S_FLUSH one cycle later, which keeps
          // writes at least two cycles apart even right after a normal write.
          w_abort_nxt = 1'b1;
          if (r_stage_vld) begin
            w_state_nxt = S_FLUSH;
          end else if (w_byte_vld) begin
            w_stage_nxt     = w_byte;
            w_stage_vld_nxt = 1'b1;
            w_state_nxt     = S_FLUSH;
          end else begin
            w_state_nxt = S_DISCARD;
          end
        end else if (w_byte_vld) begin
          w_cnt_nxt       = (r_cnt == LP_MAX) ? r_cnt : r_cnt + 1'b1;
          w_stage_nxt     = w_byte;
          w_stage_vld_nxt = 1'b1;
          w_wr            = r_stage_vld;
        end
      end

      S_FLUSH: begin
        w_wr            = 1'b1;
        w_wr_del        = 1'b1;
        w_stage_vld_nxt = 1'b0;
        w_state_nxt     = (r_abort && mii_rx_dv) ? S_DISCARD : S_IDLE;
      end

      S_DISCARD: begin
        if (!mii_rx_dv) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  // Staging register, byte counter and registered FIFO interface.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_stage      <= 8'h00;
      r_stage_vld  <= 1'b0;
      r_cnt        <= '0;
      r_abort      <= 1'b0;
      r_fifo_din   <= 8'h00;
      r_fifo_del   <= 1'b0;
      r_fifo_wren  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_stage      <= w_stage_nxt;
      r_stage_vld  <= w_stage_vld_nxt;
      r_cnt        <= w_cnt_nxt;
      r_abort      <= w_abort_nxt;
      r_fifo_wren  <= w_wr;
      r_fifo_del   <= w_wr & w_wr_del;
      r_frame_done <= w_wr & w_wr_del;
      if (w_wr) begin
        r_fifo_din <= w_wr_din;
      end
    end
  end

  assign fifo_din   = r_fifo_din;
  assign fifo_del   = r_fifo_del;
  assign fifo_wren  = r_fifo_wren;
  assign frame_done = r_frame_done;

`ifdef MII_RX_STATS_EN
  logic [MII_STAT_W-1:0] r_stat_ok;
  logic [MII_STAT_W-1:0] r_stat_err;
  logic [MII_STAT_W-1:0] r_stat_drop;
  logic                  w_ev_ok;

  // Only a delimiter from a frame that ended on mii_rx_dv counts as good.
  assign w_ev_ok = (r_state == S_FLUSH) && !r_abort;

  // Saturating frame statistics.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_stat_ok   <= '0;
      r_stat_err  <= '0;
      r_stat_drop <= '0;
    end else begin
      r_stat_ok   <= stat_inc(r_stat_ok, w_ev_ok);
      r_stat_err  <= stat_inc(r_stat_err, w_term_err);
      r_stat_drop <= stat_inc(r_stat_drop, w_term_drop);
    end
  end

  assign stat_ok   = r_stat_ok;
  assign stat_err  = r_stat_err;
  assign stat_drop = r_stat_drop;
`endif

endmodule
